// File: rtl/burst_sram_slave.sv
// -----------------------------------------------------------------------------
// burst_sram_slave
//
// Bus-slave scratch memory for the single-master burst protocol. Transactions
// whose address falls inside a 4 KiB window are decoded; read bursts are
// streamed back one word per cycle and write bursts are absorbed with
// per-byte enables into a 1024 x 32 single-port synchronous RAM.
//
// Parameters:
//   baseAddress     window base, only bits [31:12] are compared
//   readWaitStates  extra cycles (0..15) before the first read word
//
// Ports:
//   clock              system clock, rising edge
//   reset              synchronous, active-low
//   beginTransactionIn address-phase strobe
//   readNotWriteIn     1 = read, 0 = write (valid with begin)
//   byteEnablesIn      write byte lanes (valid with begin)
//   burstSizeIn        words minus one (valid with begin)
//   addressDataIn      address at begin, write data with dataValidIn
//   dataValidIn        master write-data strobe
//   endTransactionIn   master end of write burst
//   addressDataOut     read data, 0 whenever dataValidOut is low
//   dataValidOut       read-data strobe
//   endTransactionOut  slave end of read burst (one-cycle pulse)
//   busyOut            write back-pressure (one cycle after a write begin)
//   busErrorOut        one-cycle pulse on a misaligned begin
// -----------------------------------------------------------------------------
module burst_sram_slave #(
  parameter logic [31:0] baseAddress    = 32'h4000_0000,
  parameter int unsigned readWaitStates = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic        readNotWriteIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busyOut,
  output logic        busErrorOut
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] READ_WAIT   = 3'd1;
  localparam logic [2:0] READ_BURST  = 3'd2;
  localparam logic [2:0] READ_END    = 3'd3;
  localparam logic [2:0] WRITE_SETUP = 3'd4;
  localparam logic [2:0] WRITE       = 3'd5;
  localparam logic [2:0] ERR_READ    = 3'd6;
  localparam logic [2:0] ERR_WRITE   = 3'd7;

  localparam logic [3:0] WAIT_LAST = 4'(readWaitStates);

  logic [2:0]  state;
  logic [9:0]  index;      // next RAM word to read or write, wraps in window
  logic [8:0]  remaining;  // words still to transfer (burstSize + 1 at begin)
  logic [3:0]  be_q;
  logic [3:0]  wait_cnt;
  logic        err_first;  // first cycle in an error state raises busErrorOut
  logic [31:0] ram_q;
  logic [31:0] mem [1024];

  logic selected;
  logic aligned;
  logic ram_re;
  logic ram_we;

  assign selected = beginTransactionIn &&
                    (addressDataIn[31:12] == baseAddress[31:12]);
  assign aligned  = (addressDataIn[1:0] == 2'b00);

  // RAM strobes are gated by reset so that an abandoned burst cannot touch
  // memory in the cycle the reset is sampled.
  assign ram_re = reset &&
                  (((state == READ_WAIT) && (wait_cnt == WAIT_LAST)) ||
                   ((state == READ_BURST) && (remaining != 9'd0)));
  assign ram_we = reset && (state == WRITE) && dataValidIn &&
                  (remaining != 9'd0);

  // NOTE: the storage array has no reset; contents survive a bus reset and a
  // resettable RAM would not map onto a memory macro.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[index][8*b +: 8] <= addressDataIn[8*b +: 8];
      end
    end
    if (ram_re) ram_q <= mem[index];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      index             <= '0;
      remaining         <= '0;
      be_q              <= '0;
      wait_cnt          <= '0;
      err_first         <= 1'b0;
      addressDataOut    <= '0;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
      busyOut           <= 1'b0;
      busErrorOut       <= 1'b0;
    end else begin
      // Every output is a pulse or a strobe: default low each cycle.
      addressDataOut    <= '0;
      dataValidOut      <= 1'b0;
      endTransactionOut <= 1'b0;
      busyOut           <= 1'b0;
      busErrorOut       <= 1'b0;

      case (state)
        IDLE: begin
          if (selected) begin
            index     <= addressDataIn[11:2];
            remaining <= {1'b0, burstSizeIn} + 9'd1;
            be_q      <= byteEnablesIn;
            wait_cnt  <= '0;
            err_first <= 1'b1;
            if (!aligned) state <= readNotWriteIn ? ERR_READ : ERR_WRITE;
            else          state <= readNotWriteIn ? READ_WAIT : WRITE_SETUP;
          end
        end

        READ_WAIT: begin
          // The first RAM read is issued on the final wait cycle so its
          // data is ready to register out on the first burst cycle.
          if (wait_cnt == WAIT_LAST) begin
            index     <= index + 10'd1;
            remaining <= remaining - 9'd1;
            state     <= READ_BURST;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        READ_BURST: begin
          addressDataOut <= ram_q;
          dataValidOut   <= 1'b1;
          if (remaining == 9'd0) begin
            state <= READ_END;
          end else begin
            index     <= index + 10'd1;
            remaining <= remaining - 9'd1;
          end
        end

        READ_END: begin
          endTransactionOut <= 1'b1;
          state             <= IDLE;
        end

        WRITE_SETUP: begin
          busyOut <= 1'b1;
          state   <= WRITE;
        end

        WRITE: begin
          if (ram_we) begin
            index     <= index + 10'd1;
            remaining <= remaining - 9'd1;
          end
          if (endTransactionIn) state <= IDLE;
        end

        ERR_READ: begin
          if (err_first) begin
            busErrorOut <= 1'b1;
            err_first   <= 1'b0;
          end else begin
            endTransactionOut <= 1'b1;
            state             <= IDLE;
          end
        end

        ERR_WRITE: begin
          if (err_first) begin
            busErrorOut <= 1'b1;
            err_first   <= 1'b0;
          end else if (endTransactionIn) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_burst_sram_slave
//
// Self-checking bench for burst_sram_slave. A word-array model of the window
// is updated on every write burst; read bursts are checked cycle by cycle
// against the protocol timing (first word at T+2+wait, end pulse after the
// last word, zero data outside valid cycles).
// -----------------------------------------------------------------------------
module tb_burst_sram_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          WS   = 0;

  logic        clock;
  logic        reset;
  logic        beginTransactionIn;
  logic        readNotWriteIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyOut;
  logic        busErrorOut;

  burst_sram_slave #(
    .baseAddress   (BASE),
    .readWaitStates(WS)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .readNotWriteIn    (readNotWriteIn),
    .byteEnablesIn     (byteEnablesIn),
    .burstSizeIn       (burstSizeIn),
    .addressDataIn     (addressDataIn),
    .dataValidIn       (dataValidIn),
    .endTransactionIn  (endTransactionIn),
    .addressDataOut    (addressDataOut),
    .dataValidOut      (dataValidOut),
    .endTransactionOut (endTransactionOut),
    .busyOut           (busyOut),
    .busErrorOut       (busErrorOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_mem [1024];
  logic [31:0] wdata_q [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic dv,
                            input logic [31:0] data, input logic endt,
                            input logic busy, input logic berr);
    check({tag, ".dv"},   32'(dataValidOut),      32'(dv));
    check({tag, ".data"}, addressDataOut,         data);
    check({tag, ".endt"}, 32'(endTransactionOut), 32'(endt));
    check({tag, ".busy"}, 32'(busyOut),           32'(busy));
    check({tag, ".berr"}, 32'(busErrorOut),       32'(berr));
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_begin(input logic [31:0] addr, input logic rnw,
                             input int bsize, input logic [3:0] be);
    beginTransactionIn = 1'b1;
    readNotWriteIn     = rnw;
    byteEnablesIn      = be;
    burstSizeIn        = 8'(bsize);
    addressDataIn      = addr;
    tick();
    beginTransactionIn = 1'b0;
    addressDataIn      = '0;
  endtask

  // Sends every word in wdata_q; only the first bsize+1 reach memory.
  task automatic write_burst(input logic [31:0] addr, input int bsize,
                             input logic [3:0] be, input bit gaps);
    int          n   = wdata_q.size();
    int          idx = int'(addr[11:2]);
    logic [31:0] mask;
    drive_begin(addr, 1'b0, bsize, be);
    check("wr_busy_T", 32'(busyOut), 32'd0);
    tick();
    check("wr_busy_T1", 32'(busyOut), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 2; g++) begin
          if ($urandom_range(0, 1) == 0) begin
            dataValidIn   = 1'b0;
            addressDataIn = $urandom;
            tick();
          end
        end
      end
      dataValidIn      = 1'b1;
      addressDataIn    = wdata_q[i];
      endTransactionIn = (i == n - 1);
      tick();
      check("wr_busy_data", 32'(busyOut), 32'd0);
    end
    dataValidIn      = 1'b0;
    endTransactionIn = 1'b0;
    addressDataIn    = '0;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    for (int i = 0; i < n && i <= bsize; i++) begin
      model_mem[(idx + i) % 1024] =
        (model_mem[(idx + i) % 1024] & ~mask) | (wdata_q[i] & mask);
    end
    wdata_q.delete();
  endtask

  // Checks every output on every cycle of a read burst. abort_k >= 0 pulls
  // reset low after the check at offset abort_k and expects silence after.
  task automatic read_burst(input logic [31:0] addr, input int bsize,
                            input int abort_k);
    int          idx   = int'(addr[11:2]);
    int          first = 2 + WS;
    int          last  = first + bsize;
    int          endc  = last + 1;
    logic        ev;
    logic [31:0] ed;
    drive_begin(addr, 1'b1, bsize, 4'hF);
    check_outs("rd_T", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= endc + 1; k++) begin
      tick();
      ev = (k >= first) && (k <= last);
      ed = ev ? model_mem[(idx + k - first) % 1024] : 32'd0;
      check_outs($sformatf("rd_%0h_k%0d", addr[11:0], k), ev, ed,
                 (k == endc), 1'b0, 1'b0);
      if (k == abort_k) begin
        reset = 1'b0;
        tick();
        check_outs("rst_mid", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_outs("rst_after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        return;
      end
    end
  endtask

  initial begin
    reset              = 1'b0;
    beginTransactionIn = 1'b0;
    readNotWriteIn     = 1'b0;
    byteEnablesIn      = '0;
    burstSizeIn        = '0;
    addressDataIn      = '0;
    dataValidIn        = 1'b0;
    endTransactionIn   = 1'b0;
    tick();
    tick();
    check_outs("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();

    // Fill the whole window with maximum-length bursts.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) wdata_q.push_back($urandom);
      write_burst(BASE + 32'(b * 1024), 255, 4'hF, 1'b0);
    end
    read_burst(BASE + 32'h3F0, 255, -1);

    // Directed write/readback at base+0x10.
    wdata_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    write_burst(BASE + 32'h10, 3, 4'hF, 1'b0);
    read_burst(BASE + 32'h10, 3, -1);

    // Read that wraps from word 1023 to word 0.
    read_burst(BASE + 32'hFF8, 3, -1);

    // Byte-enable merge: 0xAABBCCDD over 0x12345678 with BE=0011.
    wdata_q = '{32'h1234_5678};
    write_burst(BASE + 32'h100, 0, 4'hF, 1'b0);
    wdata_q = '{32'hAABB_CCDD};
    write_burst(BASE + 32'h100, 0, 4'b0011, 1'b0);
    check("be_model", model_mem[64], 32'h1234_CCDD);
    read_burst(BASE + 32'h100, 0, -1);

    // Words beyond burstSize+1 are discarded.
    wdata_q = '{32'hCAFE_0001, 32'hCAFE_0002, 32'hDEAD_0003, 32'hDEAD_0004};
    write_burst(BASE + 32'h200, 1, 4'hF, 1'b1);
    read_burst(BASE + 32'h200, 3, -1);

    // Misaligned read: error pulse, then end pulse, no data.
    drive_begin(BASE + 32'h2, 1'b1, 3, 4'hF);
    check_outs("erd_T", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("erd_T1", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("erd_T2", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("erd_T3", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Misaligned write: error pulse, data ignored until endTransactionIn.
    drive_begin(BASE + 32'h6, 1'b0, 1, 4'hF);
    tick();
    check_outs("ewr_T1", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      dataValidIn   = 1'b1;
      addressDataIn = 32'hBAD0_0000 + 32'(i);
      tick();
      check_outs("ewr_data", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    end
    endTransactionIn = 1'b1;
    tick();
    dataValidIn      = 1'b0;
    endTransactionIn = 1'b0;
    addressDataIn    = '0;
    read_burst(BASE, 2, -1);

    // Begins outside the window produce no activity.
    drive_begin(32'h5000_0000, 1'b1, 3, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_outs("unsel_rd", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    end
    drive_begin(32'h5000_0010, 1'b0, 0, 4'hF);
    tick();
    check_outs("unsel_wr", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an 8-word read, then confirm RAM intact.
    read_burst(BASE + 32'h300, 7, 2 + WS + 2);
    read_burst(BASE + 32'h300, 7, -1);

    // Randomized bursts against the model.
    for (int r = 0; r < 8; r++) begin
      int          wn;
      int          bs;
      logic [31:0] a;
      logic [3:0]  be;
      bs = $urandom_range(0, 7);
      wn = bs + 1 + $urandom_range(0, 1);
      a  = BASE + {20'd0, 10'($urandom), 2'b00};
      be = 4'($urandom_range(1, 15));
      for (int i = 0; i < wn; i++) wdata_q.push_back($urandom);
      write_burst(a, bs, be, 1'b1);
      read_burst(a, bs, -1);
      read_burst(BASE + {20'd0, 10'($urandom), 2'b00},
                 $urandom_range(0, 7), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/burst_sram_slave.md
# burst_sram_slave

Bus-slave scratch memory that answers the single-master burst protocol driven by the DMA custom-instruction block: it decodes transactions addressed to its window, streams read bursts back word by word and absorbs write bursts from the bus. It sits on the shared bus downstream of the arbiter, so it is the target of the DMA's DO_READ / DO_WRITE phases. Contents are held in a single-port synchronous RAM internal to the block.

## Interface
- baseAddress, 32'h4000_0000, window base; window is 4 KiB, only bits [31:12] are decoded
- readWaitStates, 0, extra cycles (0..15) inserted between address phase and first read word

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- beginTransactionIn  in  1  address-phase strobe
- readNotWriteIn  in  1  valid with beginTransactionIn
- byteEnablesIn  in  4  valid with beginTransactionIn
- burstSizeIn  in  8  words minus one, valid with beginTransactionIn
- addressDataIn  in  32  address at begin, write data when dataValidIn
- dataValidIn  in  1  master write-data strobe
- endTransactionIn  in  1  master end of write burst
- addressDataOut  out  32  read data, 0 when dataValidOut low
- dataValidOut  out  1  read-data strobe
- endTransactionOut  out  1  slave end of read burst, one-cycle pulse
- busyOut  out  1  write back-pressure
- busErrorOut  out  1  one-cycle error pulse

## Operation
- Selected when beginTransactionIn=1 and addressDataIn[31:12]==baseAddress[31:12]; unselected begins ignored, stay IDLE, all outputs 0.
- Latch at begin: word index = addressDataIn[11:2] (10 bits), remaining = burstSizeIn (9-bit count, burstSize+1 words), byteEnables, readNotWrite.
- Error: selected begin with addressDataIn[1:0]!=0 → busErrorOut pulse; read → ERR_READ, write → ERR_WRITE. No memory access.
- States: IDLE, READ_WAIT, READ_BURST, READ_END, WRITE_SETUP, WRITE, ERR_READ, ERR_WRITE.
- IDLE → READ_WAIT (read) or WRITE_SETUP (write) on selected, aligned begin.
- READ_WAIT: counts readWaitStates cycles, issues RAM read of first index on last one → READ_BURST.
- READ_BURST: one word per cycle, dataValidOut=1, index +1 mod 1024 (wraps within window), remaining −1; after last word → READ_END.
- READ_END: endTransactionOut=1 one cycle → IDLE.
- WRITE_SETUP: busyOut=1 one cycle → WRITE.
- WRITE: each dataValidIn=1 writes addressDataIn to RAM[index] with latched byte enables (per-byte), index +1 mod 1024, remaining −1. Words after remaining reaches 0 are discarded. endTransactionIn=1 → IDLE (a data word in the same cycle is still written).
- ERR_READ: endTransactionOut=1 next cycle → IDLE. ERR_WRITE: ignore data, wait for endTransactionIn → IDLE.
- endTransactionIn during read states ignored. beginTransactionIn outside IDLE ignored.
- Reset (reset=0): state IDLE, all outputs 0 on next edge, RAM contents unchanged; reset mid-burst abandons the burst without endTransactionOut.

## Timing
- All outputs registered; reset value 0 for every output.
- Begin sampled at edge T. Read: first dataValidOut at T+2+readWaitStates, burstSize+1 consecutive valid cycles, endTransactionOut the cycle after the last word.
- Write: busyOut high exactly cycle T+1; master data accepted from T+2 on any cycle with dataValidIn=1 (gaps allowed).
- Error: busErrorOut high cycle T+1; ERR_READ endTransactionOut high cycle T+2.
- Bus is wired-OR: addressDataOut must be 0 whenever dataValidOut=0.

## Test plan
- Write burst base+0x10, burstSize=3, data 0x11,0x22,0x33,0x44, BE=F → busyOut at T+1 only; read back same burst with readWaitStates=0 → valid at T+2..T+5 with those values, endTransactionOut at T+6.
- Read burst at word 1022 with burstSize=3 → words 1022,1023,0,1 returned (wrap), addressDataOut 0 between/after valids.
- Write with BE=4'b0011 of 0xAABBCCDD over 0x12345678 → readback 0x1234CCDD.
- Begin at address 0x4000_0002 read → busErrorOut T+1, endTransactionOut T+2, no dataValidOut; write variant → busErrorOut, waits for endTransactionIn, RAM unchanged.
- Begin to 0x5000_0000 → no output activity; reset=0 during READ_BURST of 8 words → outputs 0 next cycle, IDLE, prior RAM data intact on later read.
